// File: rtl/alu_resp_checker.sv
// -----------------------------------------------------------------------------
// alu_resp_checker
//
// Checks the responses of a 32-bit ALU. Each op accepted in RUN has its
// expected 64-bit result computed at issue. The result then travels down a
// LAT-deep pipeline and is compared with alu_out_i when it reaches the tail.
// Pass and fail tallies saturate. The first failing op since start_i is
// captured in the ff_* registers, and err_o is sticky.
//
// Optional feature (macro ALU_CHK_STOP_ON_FAIL_EN):
//   When the macro is defined, the first mismatch moves RUN->HALT, flushes the
//   pipeline and freezes all counts until the next start_i. When it is left
//   undefined, HALT is unreachable and checking continues after mismatches.
//
// Parameters:
//   LAT    cycles from an accepted op to its compare (1..4)
//   CNT_W  width of the pass/fail counters
//
// Ports:
//   clk_i       clock; all logic is rising-edge
//   rst_i       synchronous active-high reset
//   start_i     enter RUN; clears counters, capture registers and pipeline
//   valid_i     op issued to the ALU this cycle
//   instr_i     opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MUL, 7 NOR)
//   in1_i/in2_i operands issued with valid_i
//   alu_out_i   ALU result under check
//   pass_cnt_o  matching compares (saturating)
//   fail_cnt_o  mismatching compares (saturating)
//   err_o       sticky, set on the first mismatch
//   busy_o      any op in flight
//   ff_instr_o  opcode of the first failing op
//   ff_exp_o    expected result of the first failing op
//   ff_got_o    received result of the first failing op
//   state_o     00 IDLE, 01 RUN, 10 HALT
// -----------------------------------------------------------------------------
module alu_resp_checker #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [2:0]       instr_i,
  input  logic [31:0]      in1_i,
  input  logic [31:0]      in2_i,
  input  logic [63:0]      alu_out_i,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [2:0]       ff_instr_o,
  output logic [63:0]      ff_exp_o,
  output logic [63:0]      ff_got_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // Reference result for one op. Logic ops and ADD/SUB produce 32 bits, and
  // those 32 bits are zero-extended, so an ADD/SUB carry never reaches 63:32.
  function automatic logic [63:0] calc_exp(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r32;
    logic [63:0] res;
    r32 = '0;
    case (op)
      3'd0:    r32 = a + b;
      3'd1:    r32 = a - b;
      3'd2:    r32 = a & b;
      3'd3:    r32 = a | b;
      3'd4:    r32 = a ^ b;
      3'd7:    r32 = ~(a | b);
      default: r32 = '0;
    endcase
    case (op)
      3'd5:    res = {63'd0, ($signed(a) < $signed(b))};
      3'd6:    res = {32'd0, a} * {32'd0, b};
      default: res = {32'd0, r32};
    endcase
    return res;
  endfunction

  state_e             state_q, state_d;
  logic [LAT-1:0]     vld_q, vld_d;
  logic [2:0]         instr_q [LAT];
  logic [63:0]        exp_q   [LAT];
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               err_q, err_d;
  logic [2:0]         ff_instr_q, ff_instr_d;
  logic [63:0]        ff_exp_q, ff_exp_d;
  logic [63:0]        ff_got_q, ff_got_d;

  logic               load;
  logic               cmp_en;
  logic               mismatch;

  assign load     = (state_q == ST_RUN) && valid_i && !start_i;
  assign cmp_en   = vld_q[LAT-1] && (state_q == ST_RUN);
  assign mismatch = cmp_en && (alu_out_i != exp_q[LAT-1]);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked register uses non-blocking assignments, so all of them
  // update from the same pre-edge values no matter how the statements are
  // ordered.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default first. That way every
  // path drives every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        // start_i has priority over the stop-on-fail halt.
        if (!start_i && mismatch) state_d = ST_HALT;
`endif
      end
      ST_HALT: if (start_i) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_o    = state_q;
    busy_o     = |vld_q;
    pass_cnt_o = pass_q;
    fail_cnt_o = fail_q;
    err_o      = err_q;
    ff_instr_o = ff_instr_q;
    ff_exp_o   = ff_exp_q;
    ff_got_o   = ff_got_q;
  end

  // ---------------------------------------------------------------------------
  // Pipeline valids: shift every cycle. They flush on start_i and whenever
  // the checker will not be in RUN on the next cycle (IDLE, or HALT entry).
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d    = '0;
    vld_d[0] = load;
    for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
    if (start_i || (state_d != ST_RUN)) vld_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // NOTE: the opcode/expected payload has no reset. It is only consumed when
  // the matching valid bit is set, and the valids are reset.
  always_ff @(posedge clk_i) begin
    instr_q[0] <= instr_i;
    exp_q[0]   <= calc_exp(instr_i, in1_i, in2_i);
    for (int i = 1; i < LAT; i++) begin
      instr_q[i] <= instr_q[i-1];
      exp_q[i]   <= exp_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and first-failure capture. start_i wins over a same-cycle compare.
  // ---------------------------------------------------------------------------
  always_comb begin
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
    ff_instr_d = ff_instr_q;
    ff_exp_d   = ff_exp_q;
    ff_got_d   = ff_got_q;
    if (start_i) begin
      pass_d     = '0;
      fail_d     = '0;
      err_d      = 1'b0;
      ff_instr_d = '0;
      ff_exp_d   = '0;
      ff_got_d   = '0;
    end else if (cmp_en) begin
      if (!mismatch) begin
        if (pass_q != {CNT_W{1'b1}}) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + CNT_W'(1);
        if (!err_q) begin
          err_d      = 1'b1;
          ff_instr_d = instr_q[LAT-1];
          ff_exp_d   = exp_q[LAT-1];
          ff_got_d   = alu_out_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_q     <= '0;
      fail_q     <= '0;
      err_q      <= 1'b0;
      ff_instr_q <= '0;
      ff_exp_q   <= '0;
      ff_got_q   <= '0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      ff_instr_q <= ff_instr_d;
      ff_exp_q   <= ff_exp_d;
      ff_got_q   <= ff_got_d;
    end
  end

endmodule

// File: tb/tb_alu_resp_checker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for alu_resp_checker.
// Three instances share one directed stimulus stream:
//   u_l1 (LAT=1, CNT_W=16), u_l4 (LAT=4, CNT_W=16), u_c2 (LAT=1, CNT_W=2).
// Each directed op carries the ALU result the bench should present; the bench
// delays that value by each instance's latency. A queue-based model predicts
// every output, and a negedge process compares all instances every cycle.
// Hand-computed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_alu_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, valid;
  logic [2:0]  instr;
  logic [31:0] in1, in2;
  logic [63:0] got_in;
  logic [63:0] alu0 = '0, alu1 = '0, alu2 = '0;
  bit          chk_en = 1'b0;

  logic [15:0] p0, f0, p1, f1;
  logic [1:0]  p2, f2;
  logic        e0, e1, e2, b0, b1, b2;
  logic [2:0]  fi0, fi1, fi2;
  logic [63:0] fe0, fe1, fe2, fg0, fg1, fg2;
  logic [1:0]  s0, s1, s2;

  alu_resp_checker #(.LAT(1), .CNT_W(16)) u_l1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
    .instr_i(instr), .in1_i(in1), .in2_i(in2), .alu_out_i(alu0),
    .pass_cnt_o(p0), .fail_cnt_o(f0), .err_o(e0), .busy_o(b0),
    .ff_instr_o(fi0), .ff_exp_o(fe0), .ff_got_o(fg0), .state_o(s0));

  alu_resp_checker #(.LAT(4), .CNT_W(16)) u_l4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
    .instr_i(instr), .in1_i(in1), .in2_i(in2), .alu_out_i(alu1),
    .pass_cnt_o(p1), .fail_cnt_o(f1), .err_o(e1), .busy_o(b1),
    .ff_instr_o(fi1), .ff_exp_o(fe1), .ff_got_o(fg1), .state_o(s1));

  alu_resp_checker #(.LAT(1), .CNT_W(2)) u_c2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
    .instr_i(instr), .in1_i(in1), .in2_i(in2), .alu_out_i(alu2),
    .pass_cnt_o(p2), .fail_cnt_o(f2), .err_o(e2), .busy_o(b2),
    .ff_instr_o(fi2), .ff_exp_o(fe2), .ff_got_o(fg2), .state_o(s2));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: in-flight ops are kept as a queue of
  // (instance, due cycle, opcode, expected, value to present).
  // ---------------------------------------------------------------------------
  typedef struct {
    int          inst;
    int          due;
    logic [2:0]  op;
    logic [63:0] exp;
    logic [63:0] got;
  } ent_t;

  ent_t        mq[$];
  int          cyc = 0;
  int          m_state [3];   // 0 IDLE, 1 RUN, 2 HALT
  int          m_pass  [3];
  int          m_fail  [3];
  bit          m_err   [3];
  logic [2:0]  m_ffi   [3];
  logic [63:0] m_ffe   [3];
  logic [63:0] m_ffg   [3];

  function automatic int lat_of(input int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic int cmax(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic logic [63:0] exp_of(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0]   lo;
    longint signed sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = 32'h0;
    case (op)
      3'd0: lo = a + b;
      3'd1: lo = a - b;
      3'd2: lo = a & b;
      3'd3: lo = a | b;
      3'd4: lo = a ^ b;
      3'd7: lo = ~(a | b);
      3'd5: return (sa < sb) ? 64'd1 : 64'd0;
      default: return 64'(a) * 64'(b);
    endcase
    return {32'h0, lo};
  endfunction

  function automatic logic [63:0] alu_now(input int k);
    case (k)
      0:       return alu0;
      1:       return alu1;
      default: return alu2;
    endcase
  endfunction

  task automatic drop_all(input int k);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].inst == k) mq.delete(i);
  endtask

  task automatic clear_inst(input int k);
    m_pass[k] = 0; m_fail[k] = 0; m_err[k] = 1'b0;
    m_ffi[k] = '0; m_ffe[k] = '0; m_ffg[k] = '0;
    drop_all(k);
  endtask

  task automatic model_step(input int k);
    bit   hit;
    int   idx;
    ent_t e;
    hit = 1'b0;
    idx = 0;
    if (rst) begin
      m_state[k] = 0;
      clear_inst(k);
      return;
    end
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].inst == k && mq[i].due == cyc) begin
        hit = 1'b1; idx = i; e = mq[i];
      end
    if (hit) mq.delete(idx);
    if (start) begin
      m_state[k] = 1;
      clear_inst(k);
      return;
    end
    if (hit) begin
      if (alu_now(k) == e.exp) begin
        if (m_pass[k] < cmax(k)) m_pass[k]++;
      end else begin
        if (m_fail[k] < cmax(k)) m_fail[k]++;
        if (!m_err[k]) begin
          m_err[k] = 1'b1; m_ffi[k] = e.op; m_ffe[k] = e.exp; m_ffg[k] = alu_now(k);
        end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        m_state[k] = 2;
        drop_all(k);
`endif
      end
    end
    if (m_state[k] == 1 && valid)
      mq.push_back('{k, cyc + lat_of(k), instr, exp_of(instr, in1, in2), got_in});
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) model_step(k);
  end

  function automatic logic [63:0] next_got(input int k);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].inst == k && mq[i].due == cyc + 1) return mq[i].got;
    return {$urandom, $urandom};
  endfunction

  function automatic int n_inflight(input int k);
    int n;
    n = 0;
    foreach (mq[i]) if (mq[i].inst == k) n++;
    return n;
  endfunction

  task automatic cmp_inst(input int k, input logic [15:0] pass, input logic [15:0] fail,
                          input logic err, input logic busy, input logic [1:0] st,
                          input logic [2:0] ffi, input logic [63:0] ffe,
                          input logic [63:0] ffg);
    check($sformatf("u%0d.pass_cnt", k), 64'(pass), 64'(m_pass[k]));
    check($sformatf("u%0d.fail_cnt", k), 64'(fail), 64'(m_fail[k]));
    check($sformatf("u%0d.err", k),      64'(err),  64'(m_err[k]));
    check($sformatf("u%0d.busy", k),     64'(busy), 64'(n_inflight(k) != 0));
    check($sformatf("u%0d.state", k),    64'(st),   64'(m_state[k]));
    check($sformatf("u%0d.ff_instr", k), 64'(ffi),  64'(m_ffi[k]));
    check($sformatf("u%0d.ff_exp", k),   ffe,       m_ffe[k]);
    check($sformatf("u%0d.ff_got", k),   ffg,       m_ffg[k]);
  endtask

  // Compare every cycle away from the active edge, then present the ALU
  // results that are due at the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, p0, f0, e0, b0, s0, fi0, fe0, fg0);
      cmp_inst(1, p1, f1, e1, b1, s1, fi1, fe1, fg1);
      cmp_inst(2, {14'd0, p2}, {14'd0, f2}, e2, b2, s2, fi2, fe2, fg2);
    end
    alu0 = next_got(0);
    alu1 = next_got(1);
    alu2 = next_got(2);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic op(input logic [2:0] o, input logic [31:0] a,
                    input logic [31:0] b, input logic [63:0] g);
    valid = 1'b1; instr = o; in1 = a; in2 = b; got_in = g;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] g;
  } vec_t;

  vec_t burst [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    burst[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0};
    burst[1] = '{3'd1, 32'h0000_0000, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
    burst[2] = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000};
    burst[3] = '{3'd3, 32'h0F0F_0000, 32'h0000_00F0, 64'h0000_0000_0F0F_00F0};
    burst[4] = '{3'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 64'h0000_0000_5555_5555};
    burst[5] = '{3'd5, 32'h0000_0001, 32'h8000_0000, 64'h0};
    burst[6] = '{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    burst[7] = '{3'd7, 32'h0000_0000, 32'h0000_0000, 64'h0000_0000_FFFF_FFFF};

    rst = 1'b1; start = 1'b0; valid = 1'b0;
    instr = '0; in1 = '0; in2 = '0; got_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    // Reset state
    check("rst.pass", 64'(p0), 64'd0);
    check("rst.busy", 64'(b0), 64'd0);
    check("rst.state", 64'(s0), 64'd0);
    rst = 1'b0;

    // valid_i in IDLE is ignored
    op(3'd0, 32'd1, 32'd1, 64'd2);
    idle(5);
    check("idle_ignore.busy4", 64'(b1), 64'd0);

    // ADD 3+2 with result 5 one cycle later
    pulse_start();
    check("start.state", 64'(s0), 64'd1);
    op(3'd0, 32'd3, 32'd2, 64'h5);
    idle(5);
    check("add.pass", 64'(p0), 64'd1);
    check("add.err", 64'(e0), 64'd0);

    // MUL full product, SLT signed
    op(3'd6, 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE);
    op(3'd5, 32'hFFFF_FFFF, 32'd1, 64'd1);
    idle(5);
    check("mul_slt.pass", 64'(p0), 64'd3);
    check("mul_slt.fail", 64'(f0), 64'd0);

    // Two mismatches; the first is captured
    pulse_start();
    op(3'd1, 32'd3, 32'd2, 64'd1);
    op(3'd3, 32'd4, 32'd2, 64'd7);
    op(3'd2, 32'd4, 32'd5, 64'd5);
    idle(5);
    check("fail.ff_instr", 64'(fi0), 64'd3);
    check("fail.ff_exp", fe0, 64'd6);
    check("fail.ff_got", fg0, 64'd7);
    check("fail.pass", 64'(p0), 64'd1);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    check("fail.fail_cnt", 64'(f0), 64'd1);
    check("fail.state", 64'(s0), 64'd2);
`else
    check("fail.fail_cnt", 64'(f0), 64'd2);
    check("fail.state", 64'(s0), 64'd1);
`endif

    // start_i in the same cycle as a compare: start wins, valid dropped
    pulse_start();
    op(3'd0, 32'd1, 32'd1, 64'd2);
    start = 1'b1; valid = 1'b1; instr = 3'd4; in1 = 32'd1; in2 = 32'd1; got_in = 64'd0;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    check("start_wins.pass", 64'(p0), 64'd0);
    check("start_wins.busy", 64'(b0), 64'd0);
    idle(5);

    // Eight back-to-back ops, all correct
    foreach (burst[i]) op(burst[i].o, burst[i].a, burst[i].b, burst[i].g);
    idle(3);
    check("burst.busy4_last", 64'(b1), 64'd1);
    idle(1);
    check("burst.busy4_done", 64'(b1), 64'd0);
    check("burst.pass4", 64'(p1), 64'd8);
    check("burst.pass1", 64'(p0), 64'd8);
    check("burst.sat2", 64'(p2), 64'd3);

    // Reset with ops in flight
    pulse_start();
    op(3'd0, 32'd1, 32'd2, 64'd3);
    op(3'd4, 32'd6, 32'd3, 64'd5);
    op(3'd2, 32'd6, 32'd3, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.pass1", 64'(p0), 64'd0);
    check("midrst.busy4", 64'(b1), 64'd0);
    check("midrst.state4", 64'(s1), 64'd0);
    idle(6);
    check("midrst.pass4_after", 64'(p1), 64'd0);
    check("midrst.fail4_after", 64'(f1), 64'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
